// File: rtl/decap_rci_lookup.sv
// Two-table cuckoo-style RCI lookup: fetches both hash buckets, compares
// the key against four entries in fixed priority, then reads the value word.
`ifndef RCI_HASH_TABLE_DEPTH_NBITS
`define RCI_HASH_TABLE_DEPTH_NBITS 10
`endif
`ifndef RCI_VALUE_DEPTH_NBITS
`define RCI_VALUE_DEPTH_NBITS 8
`endif
`ifndef RCI_VALUE_NBITS
`define RCI_VALUE_NBITS 64
`endif

module decap_rci_lookup #(
   parameter int DEPTH_NBITS       = `RCI_HASH_TABLE_DEPTH_NBITS,
   parameter int KEY_NBITS         = 32,
   parameter int VALUE_DEPTH_NBITS = `RCI_VALUE_DEPTH_NBITS,
   parameter int BUCKET_NBITS      = 2 * (1 + KEY_NBITS + VALUE_DEPTH_NBITS),
   parameter int VALUE_NBITS       = `RCI_VALUE_NBITS,
   parameter int TIMEOUT_NBITS     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,

   input  logic                         lookup_valid,
   output logic                         lookup_ready,
   input  logic [KEY_NBITS-1:0]         lookup_key,
   input  logic [DEPTH_NBITS-1:0]       lookup_hash0,
   input  logic [DEPTH_NBITS-1:0]       lookup_hash1,

   output logic                         rci_hash_table0_rd,
   output logic [DEPTH_NBITS-1:0]       rci_hash_table0_raddr,
   input  logic                         rci_hash_table0_ack,
   input  logic [BUCKET_NBITS-1:0]      rci_hash_table0_rdata,

   output logic                         rci_hash_table1_rd,
   output logic [DEPTH_NBITS-1:0]       rci_hash_table1_raddr,
   input  logic                         rci_hash_table1_ack,
   input  logic [BUCKET_NBITS-1:0]      rci_hash_table1_rdata,

   output logic                         rci_value_rd,
   output logic [VALUE_DEPTH_NBITS-1:0] rci_value_raddr,
   input  logic                         rci_value_ack,
   input  logic [VALUE_NBITS-1:0]       rci_value_rdata,

   output logic                         result_valid,
   input  logic                         result_ready,
   output logic                         result_hit,
   output logic                         result_err,
   output logic [VALUE_NBITS-1:0]       result_value
);

   localparam int ENTRY_NBITS = 1 + KEY_NBITS + VALUE_DEPTH_NBITS;
   localparam logic [TIMEOUT_NBITS-1:0] TMO_MAX = '1;
   localparam logic [TIMEOUT_NBITS-1:0] TMO_LAST =
      {{(TIMEOUT_NBITS-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      IDLE,
      HT_WAIT,
      CMP,
      VAL_WAIT,
      RESP
   } state_t;

   state_t                         state_q, state_d;
   logic [KEY_NBITS-1:0]           key_q, key_d;
   logic                           ht0_rd_q, ht0_rd_d;
   logic                           ht1_rd_q, ht1_rd_d;
   logic [DEPTH_NBITS-1:0]         ht0_addr_q, ht0_addr_d;
   logic [DEPTH_NBITS-1:0]         ht1_addr_q, ht1_addr_d;
   logic [BUCKET_NBITS-1:0]        bkt0_q, bkt0_d;
   logic [BUCKET_NBITS-1:0]        bkt1_q, bkt1_d;
   logic                           got0_q, got0_d;
   logic                           got1_q, got1_d;
   logic [TIMEOUT_NBITS-1:0]       tmo_q, tmo_d;
   logic                           val_rd_q, val_rd_d;
   logic [VALUE_DEPTH_NBITS-1:0]   val_addr_q, val_addr_d;
   logic                           hit_q, hit_d;
   logic                           err_q, err_d;
   logic [VALUE_NBITS-1:0]         value_q, value_d;

   logic [ENTRY_NBITS-1:0]         e00, e01, e10, e11;
   logic                           m00, m01, m10, m11;
   logic                           any_match;
   logic [VALUE_DEPTH_NBITS-1:0]   match_ptr;
   logic [TIMEOUT_NBITS-1:0]       tmo_inc;
   logic                           ht0_done, ht1_done;

   function automatic logic ent_match(
      input logic [ENTRY_NBITS-1:0] e,
      input logic [KEY_NBITS-1:0]   k
   );
      return e[ENTRY_NBITS-1] && (e[ENTRY_NBITS-2 -: KEY_NBITS] == k);
   endfunction

   assign e00 = bkt0_q[ENTRY_NBITS-1:0];
   assign e01 = bkt0_q[2*ENTRY_NBITS-1:ENTRY_NBITS];
   assign e10 = bkt1_q[ENTRY_NBITS-1:0];
   assign e11 = bkt1_q[2*ENTRY_NBITS-1:ENTRY_NBITS];

   assign m00 = ent_match(e00, key_q);
   assign m01 = ent_match(e01, key_q);
   assign m10 = ent_match(e10, key_q);
   assign m11 = ent_match(e11, key_q);
   assign any_match = m00 | m01 | m10 | m11;

   always_comb begin
      match_ptr = '0;
      if (m00)      match_ptr = e00[VALUE_DEPTH_NBITS-1:0];
      else if (m01) match_ptr = e01[VALUE_DEPTH_NBITS-1:0];
      else if (m10) match_ptr = e10[VALUE_DEPTH_NBITS-1:0];
      else if (m11) match_ptr = e11[VALUE_DEPTH_NBITS-1:0];
   end

   // Saturating so a stuck wait can never alias back to an early count.
   assign tmo_inc  = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
   assign ht0_done = got0_q | rci_hash_table0_ack;
   assign ht1_done = got1_q | rci_hash_table1_ack;

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      ht0_rd_d   = 1'b0;
      ht1_rd_d   = 1'b0;
      ht0_addr_d = ht0_addr_q;
      ht1_addr_d = ht1_addr_q;
      bkt0_d     = bkt0_q;
      bkt1_d     = bkt1_q;
      got0_d     = got0_q;
      got1_d     = got1_q;
      tmo_d      = tmo_q;
      val_rd_d   = 1'b0;
      val_addr_d = val_addr_q;
      hit_d      = hit_q;
      err_d      = err_q;
      value_d    = value_q;

      unique case (state_q)
         IDLE: begin
            if (lookup_valid) begin
               key_d      = lookup_key;
               ht0_addr_d = lookup_hash0;
               ht1_addr_d = lookup_hash1;
               ht0_rd_d   = 1'b1;
               ht1_rd_d   = 1'b1;
               bkt0_d     = '0;
               bkt1_d     = '0;
               got0_d     = 1'b0;
               got1_d     = 1'b0;
               tmo_d      = '0;
               hit_d      = 1'b0;
               err_d      = 1'b0;
               value_d    = '0;
               state_d    = HT_WAIT;
            end
         end
         HT_WAIT: begin
            tmo_d = tmo_inc;
            if (rci_hash_table0_ack && !got0_q) begin
               bkt0_d = rci_hash_table0_rdata;
               got0_d = 1'b1;
            end
            if (rci_hash_table1_ack && !got1_q) begin
               bkt1_d = rci_hash_table1_rdata;
               got1_d = 1'b1;
            end
            if (ht0_done && ht1_done) begin
               state_d = CMP;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               hit_d   = 1'b0;
               value_d = '0;
               state_d = RESP;
            end
         end
         CMP: begin
            if (any_match) begin
               val_rd_d   = 1'b1;
               val_addr_d = match_ptr;
               tmo_d      = '0;
               state_d    = VAL_WAIT;
            end else begin
               hit_d   = 1'b0;
               err_d   = 1'b0;
               value_d = '0;
               state_d = RESP;
            end
         end
         VAL_WAIT: begin
            tmo_d = tmo_inc;
            if (rci_value_ack) begin
               value_d = rci_value_rdata;
               hit_d   = 1'b1;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               hit_d   = 1'b0;
               value_d = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            if (result_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         key_q      <= '0;
         ht0_rd_q   <= 1'b0;
         ht1_rd_q   <= 1'b0;
         ht0_addr_q <= '0;
         ht1_addr_q <= '0;
         bkt0_q     <= '0;
         bkt1_q     <= '0;
         got0_q     <= 1'b0;
         got1_q     <= 1'b0;
         tmo_q      <= '0;
         val_rd_q   <= 1'b0;
         val_addr_q <= '0;
         hit_q      <= 1'b0;
         err_q      <= 1'b0;
         value_q    <= '0;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         ht0_rd_q   <= ht0_rd_d;
         ht1_rd_q   <= ht1_rd_d;
         ht0_addr_q <= ht0_addr_d;
         ht1_addr_q <= ht1_addr_d;
         bkt0_q     <= bkt0_d;
         bkt1_q     <= bkt1_d;
         got0_q     <= got0_d;
         got1_q     <= got1_d;
         tmo_q      <= tmo_d;
         val_rd_q   <= val_rd_d;
         val_addr_q <= val_addr_d;
         hit_q      <= hit_d;
         err_q      <= err_d;
         value_q    <= value_d;
      end
   end

   assign lookup_ready          = (state_q == IDLE);
   assign result_valid          = (state_q == RESP);
   assign rci_hash_table0_rd    = ht0_rd_q;
   assign rci_hash_table1_rd    = ht1_rd_q;
   assign rci_hash_table0_raddr = ht0_addr_q;
   assign rci_hash_table1_raddr = ht1_addr_q;
   assign rci_value_rd          = val_rd_q;
   assign rci_value_raddr       = val_addr_q;
   assign result_hit            = hit_q;
   assign result_err            = err_q;
   assign result_value          = value_q;

endmodule
